// File: rtl/half_adder_bit.sv
// half_adder_bit: single combinational half-adder cell.
// Produces the 1-bit sum and carry of two 1-bit operands.
module half_adder_bit (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder_reg.sv
// half_adder_reg: WIDTH independent half-adder lanes with an optional
// output register stage, so the bank can sit directly on a pipeline
// boundary. Lanes never interact; there is no carry chain.
module half_adder_reg #(
    parameter int WIDTH        = 1,
    parameter bit REGISTER_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    // Stage p0: per-lane combinational results
    logic [WIDTH-1:0] sum_p0;
    logic [WIDTH-1:0] carry_p0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_bit u_bit (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (sum_p0[i]),
            .carry (carry_p0[i])
        );
    end

    if (REGISTER_OUT) begin : g_reg
        // Stage p1: registered outputs (1-cycle latency)
        logic             vld_p1;
        logic [WIDTH-1:0] sum_p1;
        logic [WIDTH-1:0] carry_p1;

        // valid follows in_valid every edge; reset discards any in-flight result
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= in_valid;
            end
        end

        // data captures only on a qualified cycle and otherwise holds
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_p1   <= '0;
                carry_p1 <= '0;
            end else if (in_valid) begin
                sum_p1   <= sum_p0;
                carry_p1 <= carry_p0;
            end
        end

        assign out_valid = vld_p1;
        assign sum       = sum_p1;
        assign carry     = carry_p1;
    end else begin : g_comb
        // clk and rst_n have no function in the combinational build
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign out_valid = in_valid;
        assign sum       = sum_p0;
        assign carry     = carry_p0;
    end

endmodule

// File: tb/tb_half_adder_reg.sv
// tb_half_adder_reg: self-checking bench covering a registered 1-lane bank,
// a registered 4-lane bank and a combinational 1-lane bank.
module tb_half_adder_reg;

    logic clk;
    logic rst_n;

    logic       v1, o1;
    logic [0:0] a1, b1, s1, c1;
    logic       v4, o4;
    logic [3:0] a4, b4, s4, c4;
    logic       vc, oc;
    logic [0:0] ac, bc, sc, cc;

    int errors = 0;
    int checks = 0;

    half_adder_reg #(.WIDTH(1), .REGISTER_OUT(1'b1)) dut_r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
        .out_valid(o1), .sum(s1), .carry(c1)
    );

    half_adder_reg #(.WIDTH(4), .REGISTER_OUT(1'b1)) dut_r4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4),
        .out_valid(o4), .sum(s4), .carry(c4)
    );

    half_adder_reg #(.WIDTH(1), .REGISTER_OUT(1'b0)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vc), .a(ac), .b(bc),
        .out_valid(oc), .sum(sc), .carry(cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each lane adds its two bits as integers; the low digit of the
    // two-bit total is the sum, the high digit is the carry.
    function automatic logic [7:0] ref_add(input int w, input logic [3:0] x, input logic [3:0] y);
        logic [3:0] s;
        logic [3:0] c;
        s = '0;
        c = '0;
        for (int i = 0; i < w; i++) begin
            int t;
            t = int'(x[i]) + int'(y[i]);
            s[i] = (t % 2) != 0;
            c[i] = (t / 2) != 0;
        end
        return {c, s};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic a;
        logic b;
        logic v;
        logic es;
        logic ec;
        logic ev;
    } vec_t;

    vec_t tbl[5];

    logic [3:0] exp_s4, exp_c4;
    logic       exp_v4;
    logic [7:0] r;

    initial begin
        tbl[0] = '{a:1'b0, b:1'b0, v:1'b1, es:1'b0, ec:1'b0, ev:1'b1};
        tbl[1] = '{a:1'b0, b:1'b1, v:1'b1, es:1'b1, ec:1'b0, ev:1'b1};
        tbl[2] = '{a:1'b1, b:1'b0, v:1'b1, es:1'b1, ec:1'b0, ev:1'b1};
        tbl[3] = '{a:1'b1, b:1'b1, v:1'b1, es:1'b0, ec:1'b1, ev:1'b1};
        tbl[4] = '{a:1'b0, b:1'b1, v:1'b0, es:1'b0, ec:1'b1, ev:1'b0};

        rst_n = 1'b0;
        v1 = 1'b0; a1 = '0; b1 = '0;
        v4 = 1'b0; a4 = '0; b4 = '0;
        vc = 1'b0; ac = '0; bc = '0;

        // reset state
        #3;
        check("rst_sum1", 32'(s1), 32'd0);
        check("rst_carry1", 32'(c1), 32'd0);
        check("rst_vld1", 32'(o1), 32'd0);
        check("rst_sum4", 32'(s4), 32'd0);
        check("rst_carry4", 32'(c4), 32'd0);
        check("rst_vld4", 32'(o4), 32'd0);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // no output change before the first qualified edge
        @(posedge clk); #1;
        check("post_rel_vld1", 32'(o1), 32'd0);
        check("post_rel_sum1", 32'(s1), 32'd0);

        // truth table and hold on the 1-lane registered bank
        for (int i = 0; i < 5; i++) begin
            a1 = tbl[i].a; b1 = tbl[i].b; v1 = tbl[i].v;
            @(posedge clk); #1;
            check($sformatf("tt_sum[%0d]", i), 32'(s1), 32'(tbl[i].es));
            check($sformatf("tt_carry[%0d]", i), 32'(c1), 32'(tbl[i].ec));
            check($sformatf("tt_vld[%0d]", i), 32'(o1), 32'(tbl[i].ev));
        end

        // asynchronous reset between edges while carry=1 is held
        #2 rst_n = 1'b0;
        #1;
        check("async_sum", 32'(s1), 32'd0);
        check("async_carry", 32'(c1), 32'd0);
        check("async_vld", 32'(o1), 32'd0);
        #2 rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b0;
        @(posedge clk); #1;
        check("rel_hold_sum", 32'(s1), 32'd0);
        check("rel_hold_carry", 32'(c1), 32'd0);
        check("rel_hold_vld", 32'(o1), 32'd0);
        a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
        @(posedge clk); #1;
        check("first_valid_sum", 32'(s1), 32'd1);
        check("first_valid_carry", 32'(c1), 32'd0);
        check("first_valid_vld", 32'(o1), 32'd1);
        v1 = 1'b0;

        // 4-lane registered bank: named example, exhaustive sweep, random with holds
        a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
        @(posedge clk); #1;
        check("ex_sum4", 32'(s4), 32'b0110);
        check("ex_carry4", 32'(c4), 32'b1000);

        for (int i = 0; i < 256; i++) begin
            logic [7:0] p;
            p = 8'(i);
            a4 = p[7:4]; b4 = p[3:0]; v4 = 1'b1;
            r = ref_add(4, a4, b4);
            @(posedge clk); #1;
            check($sformatf("sweep_sum4[%0d]", i), 32'(s4), 32'(r[3:0]));
            check($sformatf("sweep_carry4[%0d]", i), 32'(c4), 32'(r[7:4]));
        end
        r = ref_add(4, a4, b4);
        exp_s4 = r[3:0]; exp_c4 = r[7:4]; exp_v4 = 1'b1;

        for (int i = 0; i < 200; i++) begin
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            v4 = ($urandom_range(0, 3) != 0);
            if (v4) begin
                r = ref_add(4, a4, b4);
                exp_s4 = r[3:0];
                exp_c4 = r[7:4];
            end
            exp_v4 = v4;
            @(posedge clk); #1;
            check($sformatf("rnd_sum4[%0d]", i), 32'(s4), 32'(exp_s4));
            check($sformatf("rnd_carry4[%0d]", i), 32'(c4), 32'(exp_c4));
            check($sformatf("rnd_vld4[%0d]", i), 32'(o4), 32'(exp_v4));
        end
        v4 = 1'b0;

        // combinational bank: outputs track inputs with no clock edge
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            logic [2:0] p;
            p = (i < 8) ? 3'(i) : 3'($urandom);
            ac = p[2]; bc = p[1]; vc = p[0];
            #1;
            r = ref_add(1, {3'b0, ac}, {3'b0, bc});
            check($sformatf("comb_sum[%0d]", i), 32'(sc), 32'(r[0]));
            check($sformatf("comb_carry[%0d]", i), 32'(cc), 32'(r[4]));
            check($sformatf("comb_vld[%0d]", i), 32'(oc), 32'(vc));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
